ram_arbiter: RTL and testbench

//  Shares the single RAM port between the decoder fetch unit (f_*) and the garbage collector (gc_*).

---
 rtl/lisp.sv | 7 +
 rtl/ram_arb_pick.sv | 25 ++
 rtl/ram_arbiter.sv | 104 ++++++++++
 tb/tb_ram_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/lisp.sv
// lisp: shared word/address widths and arbiter state/owner encodings.
package lisp;
  localparam int WORD_SIZE = 32;
  localparam int ADDR_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_GC} arb_owner_t;
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner select plus the registered GC starve counter.
module ram_arb_pick import lisp::*; #(
  parameter int GC_STARVE_MAX = 8,
  localparam int SW = $clog2(GC_STARVE_MAX + 1)
) (
  input  logic          dec_clk,
  input  logic          dec_rst,
  input  logic          idle,
  input  logic          f_req,
  input  logic          gc_req,
  input  logic          gc_lock,
  input  logic          last_gc,
  output arb_owner_t    win,
  output logic [SW-1:0] starve
);
  localparam logic [SW-1:0] SMAX = SW'(GC_STARVE_MAX);
  always_comb
    win = (gc_req && ((gc_lock && last_gc) || starve == SMAX)) ? OWN_GC :
          f_req ? OWN_FETCH : gc_req ? OWN_GC : OWN_NONE;
  always_ff @(posedge dec_clk)
    if (dec_rst) starve <= '0;
    else if (idle)
      starve <= (!gc_req || win == OWN_GC) ? '0 :
                (win == OWN_FETCH && starve != SMAX) ? starve + 1'b1 : starve;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between fetch and GC, fetch first, GC anti-starvation and lock.
// LISP_ARB_TIMEOUT_EN adds an ACCESS timeout that acks with err = 1 and rdata = 0.
module ram_arbiter import lisp::*; #(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = WORD_SIZE,
  parameter int GC_STARVE_MAX = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              dec_clk,
  input  logic              dec_rst,
  input  logic              f_req,
  input  logic              f_we,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [DATA_W-1:0] f_wdata,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              gc_req,
  input  logic              gc_we,
  input  logic [ADDR_W-1:0] gc_addr,
  input  logic [DATA_W-1:0] gc_wdata,
  input  logic              gc_lock,
  output logic              gc_ack,
  output logic [DATA_W-1:0] gc_rdata,
  output logic              gc_err,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic              ram_rden,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data_out,
  input  logic [DATA_W-1:0] ram_data_in,
  input  logic              ram_mem_ret,
  output logic [1:0]        arb_owner
);
  arb_state_t state, state_n;
  arb_owner_t win, owner;
  logic last_gc, gsel, we, tmo;
  logic [DATA_W-1:0] rdata;
  logic [$clog2(GC_STARVE_MAX + 1)-1:0] starve;

  ram_arb_pick #(.GC_STARVE_MAX(GC_STARVE_MAX)) u_pick (
    .dec_clk(dec_clk), .dec_rst(dec_rst), .idle(state == IDLE), .f_req(f_req),
    .gc_req(gc_req), .gc_lock(gc_lock), .last_gc(last_gc), .win(win), .starve(starve)
  );

`ifdef LISP_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] tcnt;
  logic err;
  assign tmo = state == ACCESS && tcnt == TMAX && !ram_mem_ret;
  always_ff @(posedge dec_clk) begin
    tcnt <= (dec_rst || state != ACCESS) ? '0 : tcnt + 1'b1;
    err <= dec_rst ? 1'b0 : (state == ACCESS && state_n == DONE) ? tmo : err;
  end
  assign f_err = err & f_ack;
  assign gc_err = err & gc_ack;
`else
  assign tmo = 1'b0;
  assign f_err = 1'b0;
  assign gc_err = 1'b0;
`endif

  assign gsel = win == OWN_GC;
  assign we = gsel ? gc_we : f_we;
  assign arb_owner = owner;
  assign f_rdata = rdata;
  assign gc_rdata = rdata;

  always_ff @(posedge dec_clk)
    state <= dec_rst ? IDLE : state_n;
  always_comb
    state_n = state == IDLE ? (win != OWN_NONE ? ACCESS : IDLE) :
              state == ACCESS ? ((ram_mem_ret || tmo) ? DONE : ACCESS) : IDLE;

  always_ff @(posedge dec_clk)
    if (dec_rst) begin
      owner <= OWN_NONE;
      last_gc <= 1'b0;
      ram_addr_out <= '0;
      ram_data_out <= '0;
      ram_rden <= 1'b0;
      ram_wren <= 1'b0;
      f_ack <= 1'b0;
      gc_ack <= 1'b0;
      rdata <= '0;
    end else if (state == IDLE && win != OWN_NONE) begin
      owner <= win;
      last_gc <= gsel;
      ram_addr_out <= gsel ? gc_addr : f_addr;
      ram_data_out <= gsel ? gc_wdata : f_wdata;
      ram_rden <= !we;
      ram_wren <= we;
    end else if (state == ACCESS && state_n == DONE) begin
      ram_rden <= 1'b0;
      ram_wren <= 1'b0;
      rdata <= (ram_mem_ret && ram_rden) ? ram_data_in : '0;
      f_ack <= owner == OWN_FETCH;
      gc_ack <= owner == OWN_GC;
    end else if (state == DONE) begin
      f_ack <= 1'b0;
      gc_ack <= 1'b0;
      owner <= OWN_NONE;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter against hand-computed expectations.
module tb_ram_arbiter;
  import lisp::*;
  logic dec_clk = 1'b0, dec_rst = 1'b1;
  logic f_req = 0, f_we = 0, gc_req = 0, gc_we = 0, gc_lock = 0;
  logic [15:0] f_addr = 0, gc_addr = 0;
  logic [31:0] f_wdata = 0, gc_wdata = 0;
  logic f_ack, f_err, gc_ack, gc_err, ram_rden, ram_wren;
  logic [31:0] f_rdata, gc_rdata, ram_data_out;
  logic [31:0] ram_data_in = 0;
  logic ram_mem_ret = 0;
  logic [15:0] ram_addr_out;
  logic [1:0] arb_owner;
  int checks = 0, errors = 0;
  logic ret_en = 1, ret_force = 0, both_seen = 0, hist_clr = 0, any_ack;
  int delay = 0, scnt = 0, n, fcnt;
  logic [31:0] rd_val = 0;
  logic [1:0] last_own = 0;
  logic [15:0] hist = 0;

  ram_arbiter dut (
    .dec_clk(dec_clk), .dec_rst(dec_rst),
    .f_req(f_req), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata),
    .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
    .gc_req(gc_req), .gc_we(gc_we), .gc_addr(gc_addr), .gc_wdata(gc_wdata), .gc_lock(gc_lock),
    .gc_ack(gc_ack), .gc_rdata(gc_rdata), .gc_err(gc_err),
    .ram_addr_out(ram_addr_out), .ram_rden(ram_rden), .ram_wren(ram_wren),
    .ram_data_out(ram_data_out), .ram_data_in(ram_data_in), .ram_mem_ret(ram_mem_ret),
    .arb_owner(arb_owner)
  );

  always #5 dec_clk = ~dec_clk;

  // RAM model: completes `delay` cycles after a strobe first appears; writes see garbage data.
  always @(negedge dec_clk) begin
    if (ram_rden && ram_wren) both_seen = 1'b1;
    if (ram_rden || ram_wren) begin
      ram_mem_ret = ret_force || (ret_en && scnt == delay);
      ram_data_in = ram_rden ? rd_val : 32'hBAD0BAD0;
      scnt++;
    end else begin
      ram_mem_ret = ret_force;
      scnt = 0;
    end
    if (hist_clr) begin
      hist = 0;
      last_own = arb_owner;
    end else if (arb_owner != last_own) begin
      hist = {hist[13:0], arb_owner};
      last_own = arb_owner;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge dec_clk);
    #1;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(f_ack || gc_ack) && cyc < 400);
    chk("ack_seen", 64'(f_ack | gc_ack), 1);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_owner", arb_owner, 0);
    chk("rst_strobe", {ram_rden, ram_wren}, 0);
    chk("rst_ack", {f_ack, gc_ack}, 0);
    chk("rst_addr", ram_addr_out, 0);
    chk("rst_state", dut.state, IDLE);
    dec_rst = 0;
    tick();
    // 1: single fetch read, RAM returns 3 cycles after strobe
    delay = 3; rd_val = 32'hDEADBEEF;
    f_req = 1; f_we = 0; f_addr = 16'h0010;
    tick();
    chk("t1_rden", {ram_rden, ram_wren}, 2'b10);
    chk("t1_addr", ram_addr_out, 16'h0010);
    chk("t1_owner", arb_owner, 1);
    wait_ack(n);
    chk("t1_lat", n, 4);
    chk("t1_acks", {f_ack, gc_ack}, 2'b10);
    chk("t1_rdata", f_rdata, 32'hDEADBEEF);
    f_req = 0;
    tick();
    chk("t1_pulse", f_ack, 0);
    // 2: simultaneous requests, fetch first, owner 01 -> 00 -> 10 -> 00
    hist_clr = 1; tick(); hist_clr = 0;
    delay = 0; rd_val = 32'h11112222;
    f_req = 1; f_addr = 16'h0020;
    gc_req = 1; gc_we = 0; gc_addr = 16'h0030;
    wait_ack(n);
    chk("t2_first_f", {f_ack, gc_ack}, 2'b10);
    f_req = 0;
    wait_ack(n);
    chk("t2_then_gc", {f_ack, gc_ack}, 2'b01);
    chk("t2_gc_rdata", gc_rdata, 32'h11112222);
    gc_req = 0;
    tick(); tick();
    chk("t2_hist", hist, 16'h0048);
    // 3: fetch held with gc pending: 8 fetch grants, then GC forced
    f_req = 1; gc_req = 1; fcnt = 0;
    do begin
      wait_ack(n);
      if (gc_ack) break;
      fcnt++;
    end while (fcnt < 20);
    chk("t3_fgrants", fcnt, 8);
    chk("t3_gc", gc_ack, 1);
    chk("t3_starve", dut.u_pick.starve, 0);
    // 4: locked GC writes keep the bus while fetch waits
    gc_lock = 1; gc_we = 1;
    for (int i = 0; i < 4; i++) begin
      gc_addr = 16'h0100 + 16'(i);
      gc_wdata = 32'hC0DE0000 + 32'(i);
      tick(); tick();
      chk("t4_wren", {ram_rden, ram_wren}, 2'b01);
      chk("t4_wdata", ram_data_out, 32'hC0DE0000 + 32'(i));
      wait_ack(n);
      chk("t4_gc_ack", {f_ack, gc_ack}, 2'b01);
      chk("t4_wr_rdata", gc_rdata, 0);
    end
    gc_req = 0; gc_lock = 0;
    wait_ack(n);
    chk("t4_then_f", {f_ack, gc_ack}, 2'b10);
    chk("excl", both_seen, 0);
    f_req = 0;
    tick();
    // 5: RAM never returns
    ret_en = 0; f_req = 1; f_addr = 16'h0040;
    tick();
    chk("t5_strobe", ram_rden, 1);
`ifdef LISP_ARB_TIMEOUT_EN
    wait_ack(n);
    chk("t5_lat", n, 256);
    chk("t5_err", f_err, 1);
    chk("t5_rdata", f_rdata, 0);
    f_req = 0;
    tick();
`else
    any_ack = 0;
    repeat (300) begin
      tick();
      if (f_ack || gc_ack) any_ack = 1;
    end
    chk("t5_no_ack", any_ack, 0);
    chk("t5_hold", ram_rden, 1);
    chk("t5_err", f_err, 0);
`endif
    // 6: reset mid-ACCESS with a simultaneous ram_mem_ret
    f_req = 1; f_addr = 16'h0050;
    for (int i = 0; i < 10 && !ram_rden; i++) tick();
    chk("t6_strobe", ram_rden, 1);
    tick(); tick();
    dec_rst = 1; ret_force = 1;
    tick();
    chk("t6_strobe_off", {ram_rden, ram_wren}, 0);
    chk("t6_ack", {f_ack, gc_ack}, 0);
    chk("t6_state", dut.state, IDLE);
    f_req = 0; dec_rst = 0;
    any_ack = 0;
    tick();
    if (f_ack || gc_ack) any_ack = 1;
    ret_force = 0;
    repeat (3) begin
      tick();
      if (f_ack || gc_ack) any_ack = 1;
    end
    chk("t6_no_ack", any_ack, 0);
    chk("t6_owner", arb_owner, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
